// File: rtl/module_arbitro_mem.sv
// module_arbitro_mem: two-requester arbiter in front of the single main-memory
// port. Requester 0 is the instruction cache (block reads), requester 1 is the
// data cache (block reads and word writes). One transaction is in flight at a
// time: IDLE picks a winner, ISSUE talks to memory, RESP acks the requester.
//
// Optional build macro: MEM_ARB_RR_EN
//   defined   -> round-robin between requester 0 and requester 1
//   undefined -> fixed priority, requester 1 always beats requester 0
module module_arbitro_mem #(
  parameter int ADDR_WIDTH = 16,
  parameter int SIZE_BLOCK = 256,
  parameter int WORD_SIZE  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  // requester 0: block read
  input  logic                  c0_rd_rq,
  input  logic [ADDR_WIDTH-1:0] c0_rd_addr,
  output logic                  c0_rd_ack,
  output logic [SIZE_BLOCK-1:0] c0_rd_data,
  // requester 1: block read
  input  logic                  c1_rd_rq,
  input  logic [ADDR_WIDTH-1:0] c1_rd_addr,
  output logic                  c1_rd_ack,
  output logic [SIZE_BLOCK-1:0] c1_rd_data,
  // requester 1: word write
  input  logic                  c1_wr_rq,
  input  logic [ADDR_WIDTH-1:0] c1_wr_addr,
  input  logic [WORD_SIZE-1:0]  c1_wr_data,
  output logic                  c1_wr_ack,
  // memory block read
  output logic                  mem_rd_rq,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic                  mem_rd_ack,
  input  logic [SIZE_BLOCK-1:0] mem_rd_data,
  // memory word write
  output logic                  mem_wr_rq,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [WORD_SIZE-1:0]  mem_wr_data,
  input  logic                  mem_wr_ack,
  output logic                  arb_busy
);

  localparam int BLK_OFF = $clog2(SIZE_BLOCK/8);

  // Masks clear the byte offset inside a block (reads) or inside a word (writes).
  localparam logic [ADDR_WIDTH-1:0] RD_MASK = {{(ADDR_WIDTH-BLK_OFF){1'b1}}, {BLK_OFF{1'b0}}};
  localparam logic [ADDR_WIDTH-1:0] WR_MASK = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SRC_C0_RD = 2'd0,
    SRC_C1_RD = 2'd1,
    SRC_C1_WR = 2'd2
  } src_t;

  state_t                state_q, state_d;
  src_t                  src_q, src_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WORD_SIZE-1:0]  wdata_q, wdata_d;
  logic [SIZE_BLOCK-1:0] rdata_q, rdata_d;
  logic                  c0_rd_ack_q, c0_rd_ack_d;
  logic                  c1_rd_ack_q, c1_rd_ack_d;
  logic                  c1_wr_ack_q, c1_wr_ack_d;
`ifdef MEM_ARB_RR_EN
  // 1 = requester 1 was granted last, so requester 0 wins the next tie.
  logic                  last_req_q, last_req_d;
`endif

  logic c0_pend, c1_pend, pick_c1, src_is_rd;
  src_t c1_src;

  // Winner selection among pending requests, evaluated every cycle but only
  // consumed in IDLE. Inside requester 1, stores drain before refills.
  always_comb begin
    c0_pend = c0_rd_rq;
    c1_pend = c1_rd_rq | c1_wr_rq;
    c1_src  = c1_wr_rq ? SRC_C1_WR : SRC_C1_RD;
`ifdef MEM_ARB_RR_EN
    pick_c1 = c1_pend && (!c0_pend || !last_req_q);
`else
    pick_c1 = c1_pend;
`endif
  end

  assign src_is_rd = (src_q == SRC_C0_RD) || (src_q == SRC_C1_RD);

  // Next-state and registered-output logic for the IDLE/ISSUE/RESP sequence.
  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    c0_rd_ack_d = 1'b0;
    c1_rd_ack_d = 1'b0;
    c1_wr_ack_d = 1'b0;
`ifdef MEM_ARB_RR_EN
    last_req_d  = last_req_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (c0_pend || c1_pend) begin
          state_d = ST_ISSUE;
          if (pick_c1) begin
            src_d  = c1_src;
            addr_d = c1_wr_rq ? c1_wr_addr : c1_rd_addr;
            if (c1_wr_rq) wdata_d = c1_wr_data;
`ifdef MEM_ARB_RR_EN
            last_req_d = 1'b1;
`endif
          end else begin
            src_d  = SRC_C0_RD;
            addr_d = c0_rd_addr;
`ifdef MEM_ARB_RR_EN
            last_req_d = 1'b0;
`endif
          end
        end
      end
      ST_ISSUE: begin
        // Only the ack matching the current transaction type is honoured.
        if (src_is_rd && mem_rd_ack) begin
          rdata_d     = mem_rd_data;
          state_d     = ST_RESP;
          c0_rd_ack_d = (src_q == SRC_C0_RD);
          c1_rd_ack_d = (src_q == SRC_C1_RD);
        end else if ((src_q == SRC_C1_WR) && mem_wr_ack) begin
          state_d     = ST_RESP;
          c1_wr_ack_d = 1'b1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset abandons any in-flight transaction without an ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      src_q       <= SRC_C0_RD;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      c0_rd_ack_q <= 1'b0;
      c1_rd_ack_q <= 1'b0;
      c1_wr_ack_q <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_req_q  <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      c0_rd_ack_q <= c0_rd_ack_d;
      c1_rd_ack_q <= c1_rd_ack_d;
      c1_wr_ack_q <= c1_wr_ack_d;
`ifdef MEM_ARB_RR_EN
      last_req_q  <= last_req_d;
`endif
    end
  end

  // Memory request drops in the ack cycle so memory sees one request per
  // transaction.
  assign mem_rd_rq   = (state_q == ST_ISSUE) && src_is_rd && !mem_rd_ack;
  assign mem_wr_rq   = (state_q == ST_ISSUE) && (src_q == SRC_C1_WR) && !mem_wr_ack;
  assign mem_rd_addr = addr_q & RD_MASK;
  assign mem_wr_addr = addr_q & WR_MASK;
  assign mem_wr_data = wdata_q;

  assign c0_rd_ack  = c0_rd_ack_q;
  assign c1_rd_ack  = c1_rd_ack_q;
  assign c1_wr_ack  = c1_wr_ack_q;
  assign c0_rd_data = rdata_q;
  assign c1_rd_data = rdata_q;
  assign arb_busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_module_arbitro_mem.sv
// Directed bench for module_arbitro_mem with a byte-array memory model whose
// ack latency is adjustable (mem_lat cycles after the request is first seen).
module tb_module_arbitro_mem;

  logic         clk = 1'b0;
  logic         rst;
  logic         c0_rd_rq, c1_rd_rq, c1_wr_rq;
  logic [15:0]  c0_rd_addr, c1_rd_addr, c1_wr_addr;
  logic [31:0]  c1_wr_data;
  logic         c0_rd_ack, c1_rd_ack, c1_wr_ack;
  logic [255:0] c0_rd_data, c1_rd_data;
  logic         mem_rd_rq, mem_wr_rq, mem_rd_ack, mem_wr_ack;
  logic [15:0]  mem_rd_addr, mem_wr_addr;
  logic [31:0]  mem_wr_data;
  logic [255:0] mem_rd_data;
  logic         arb_busy;

  int n_chk = 0;
  int n_fail = 0;

  // memory model state
  logic [7:0]   mem [0:8191];
  logic         mem_init_done = 1'b0;
  logic         mrd_ack_m, inj_rd_ack;
  int           mem_lat;
  int           rd_cnt, wr_cnt;
  int           wr_ops = 0;
  int           wr_rq_cycles = 0;

  always #5 clk = ~clk;

  assign mem_rd_ack = mrd_ack_m | inj_rd_ack;

  module_arbitro_mem dut (
    .clk(clk), .rst(rst),
    .c0_rd_rq(c0_rd_rq), .c0_rd_addr(c0_rd_addr), .c0_rd_ack(c0_rd_ack), .c0_rd_data(c0_rd_data),
    .c1_rd_rq(c1_rd_rq), .c1_rd_addr(c1_rd_addr), .c1_rd_ack(c1_rd_ack), .c1_rd_data(c1_rd_data),
    .c1_wr_rq(c1_wr_rq), .c1_wr_addr(c1_wr_addr), .c1_wr_data(c1_wr_data), .c1_wr_ack(c1_wr_ack),
    .mem_rd_rq(mem_rd_rq), .mem_rd_addr(mem_rd_addr), .mem_rd_ack(mem_rd_ack), .mem_rd_data(mem_rd_data),
    .mem_wr_rq(mem_wr_rq), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data), .mem_wr_ack(mem_wr_ack),
    .arb_busy(arb_busy)
  );

  // Memory model: mem[i] = i[7:0] initially, acks mem_lat cycles after request.
  always @(posedge clk) begin
    if (rst) begin
      mrd_ack_m  <= 1'b0;
      mem_wr_ack <= 1'b0;
      rd_cnt     <= 0;
      wr_cnt     <= 0;
      if (!mem_init_done) begin
        for (int i = 0; i < 8192; i++) mem[i] <= i[7:0];
        mem_rd_data   <= '0;
        mem_init_done <= 1'b1;
      end
    end else begin
      if (mem_wr_rq) wr_rq_cycles <= wr_rq_cycles + 1;
      if (mrd_ack_m) mrd_ack_m <= 1'b0;
      else if (mem_rd_rq) begin
        if (rd_cnt + 1 >= mem_lat) begin
          mrd_ack_m <= 1'b1;
          rd_cnt    <= 0;
          for (int k = 0; k < 32; k++) mem_rd_data[8*k +: 8] <= mem[int'(mem_rd_addr[12:0]) + k];
        end else rd_cnt <= rd_cnt + 1;
      end
      if (mem_wr_ack) mem_wr_ack <= 1'b0;
      else if (mem_wr_rq) begin
        if (wr_cnt + 1 >= mem_lat) begin
          mem_wr_ack <= 1'b1;
          wr_cnt     <= 0;
          wr_ops     <= wr_ops + 1;
          for (int k = 0; k < 4; k++) mem[int'(mem_wr_addr[12:0]) + k] <= mem_wr_data[8*k +: 8];
        end else wr_cnt <= wr_cnt + 1;
      end
    end
  end

  // Reset with all requests high: everything idle, first grant after release.
  task automatic test_reset;
    rst = 1'b1;
    c0_rd_rq = 1'b1; c1_rd_rq = 1'b1; c1_wr_rq = 1'b1;
    c0_rd_addr = 16'h1F00; c1_rd_addr = 16'h1F00; c1_wr_addr = 16'h1F00;
    c1_wr_data = 32'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_chk++;
      if ({arb_busy, mem_rd_rq, mem_wr_rq, c0_rd_ack, c1_rd_ack, c1_wr_ack} !== 6'b0) begin
        n_fail++;
        $display("FAIL reset_ctrl cyc%0d: got %b want 000000", i,
                 {arb_busy, mem_rd_rq, mem_wr_rq, c0_rd_ack, c1_rd_ack, c1_wr_ack});
      end
      n_chk++;
      if ({c0_rd_data, c1_rd_data, mem_rd_addr, mem_wr_addr, mem_wr_data} !== '0) begin
        n_fail++;
        $display("FAIL reset_data cyc%0d: got nonzero data/addr want 0", i);
      end
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if (arb_busy !== 1'b0) begin n_fail++; $display("FAIL reset_release_idle: got %b want 0", arb_busy); end
    @(negedge clk);
    n_chk++;
    if (arb_busy !== 1'b1) begin n_fail++; $display("FAIL reset_first_grant: got %b want 1", arb_busy); end
    @(posedge clk); #1;
    rst = 1'b1;
    c0_rd_rq = 1'b0; c1_rd_rq = 1'b0; c1_wr_rq = 1'b0;
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
  endtask

  // Single c0 block read with a one-cycle memory.
  task automatic test_c0_read;
    logic [255:0] exp;
    for (int k = 0; k < 32; k++) exp[8*k +: 8] = 8'(8'h20 + k);
    c0_rd_addr = 16'h1234; c0_rd_rq = 1'b1;
    @(negedge clk); // cycle 0
    n_chk++;
    if (arb_busy !== 1'b0) begin n_fail++; $display("FAIL c0rd_cyc0_busy: got %b want 0", arb_busy); end
    @(negedge clk); // cycle 1
    n_chk++;
    if (mem_rd_rq !== 1'b1) begin n_fail++; $display("FAIL c0rd_memrq: got %b want 1", mem_rd_rq); end
    n_chk++;
    if (mem_rd_addr !== 16'h1220) begin n_fail++; $display("FAIL c0rd_addr: got %h want 1220", mem_rd_addr); end
    @(negedge clk); // cycle 2
    n_chk++;
    if ({mem_rd_rq, c0_rd_ack} !== 2'b00) begin n_fail++; $display("FAIL c0rd_cyc2: got rq,ack=%b want 00", {mem_rd_rq, c0_rd_ack}); end
    @(negedge clk); // cycle 3
    n_chk++;
    if ({c0_rd_ack, c1_rd_ack, c1_wr_ack} !== 3'b100) begin
      n_fail++; $display("FAIL c0rd_ack: got %b want 100", {c0_rd_ack, c1_rd_ack, c1_wr_ack});
    end
    n_chk++;
    if (c0_rd_data !== exp) begin n_fail++; $display("FAIL c0rd_data: got %h want %h", c0_rd_data, exp); end
    @(posedge clk); #1 c0_rd_rq = 1'b0;
    @(negedge clk); // cycle 4
    n_chk++;
    if ({c0_rd_ack, arb_busy} !== 2'b00) begin n_fail++; $display("FAIL c0rd_cyc4: got ack,busy=%b want 00", {c0_rd_ack, arb_busy}); end
    @(posedge clk); #1;
  endtask

  // c1 write and read raised together: write first, then the read sees it.
  task automatic test_wr_then_rd;
    int ops0, rqc0;
    ops0 = wr_ops; rqc0 = wr_rq_cycles;
    c1_wr_addr = 16'h0043; c1_wr_data = 32'hDEADBEEF; c1_wr_rq = 1'b1;
    c1_rd_addr = 16'h0040; c1_rd_rq = 1'b1;
    @(negedge clk); // cycle 0
    @(negedge clk); // cycle 1
    n_chk++;
    if ({mem_wr_rq, mem_rd_rq} !== 2'b10) begin n_fail++; $display("FAIL wr_first: got wr,rd=%b want 10", {mem_wr_rq, mem_rd_rq}); end
    n_chk++;
    if (mem_wr_addr !== 16'h0040) begin n_fail++; $display("FAIL wr_addr: got %h want 0040", mem_wr_addr); end
    n_chk++;
    if (mem_wr_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_data: got %h want deadbeef", mem_wr_data); end
    @(negedge clk); // cycle 2
    @(negedge clk); // cycle 3
    n_chk++;
    if ({c1_wr_ack, c1_rd_ack, c0_rd_ack} !== 3'b100) begin
      n_fail++; $display("FAIL wr_ack: got %b want 100", {c1_wr_ack, c1_rd_ack, c0_rd_ack});
    end
    @(posedge clk); #1 c1_wr_rq = 1'b0;
    @(negedge clk); // cycle 4
    @(negedge clk); // cycle 5
    n_chk++;
    if (mem_rd_rq !== 1'b1 || mem_rd_addr !== 16'h0040) begin
      n_fail++; $display("FAIL rd_after_wr_issue: got rq=%b addr=%h want 1 0040", mem_rd_rq, mem_rd_addr);
    end
    @(negedge clk); // cycle 6
    @(negedge clk); // cycle 7
    n_chk++;
    if ({c1_rd_ack, c1_wr_ack} !== 2'b10) begin n_fail++; $display("FAIL rd_after_wr_ack: got %b want 10", {c1_rd_ack, c1_wr_ack}); end
    n_chk++;
    if (c1_rd_data[39:0] !== 40'h44_DEADBEEF) begin
      n_fail++; $display("FAIL rd_after_wr_data: got %h want 44deadbeef", c1_rd_data[39:0]);
    end
    @(posedge clk); #1 c1_rd_rq = 1'b0;
    n_chk++;
    if (wr_ops - ops0 !== 1 || wr_rq_cycles - rqc0 !== 1) begin
      n_fail++; $display("FAIL single_write: got ops=%0d rq_cycles=%0d want 1 1", wr_ops - ops0, wr_rq_cycles - rqc0);
    end
  endtask

  // Memory acks 5 cycles after the request: ISSUE stretches, ack follows by one.
  task automatic test_slow_mem;
    int rqc, mack, ack_cyc, ack_cnt, busy_bad;
    logic drop;
    rqc = 0; mack = -1; ack_cyc = -1; ack_cnt = 0; busy_bad = 0; drop = 1'b0;
    mem_lat = 5;
    c0_rd_addr = 16'h0080; c0_rd_rq = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      if (mem_rd_rq) rqc++;
      if (cyc >= 1 && ack_cyc < 0 && !arb_busy) busy_bad++;
      if (mem_rd_ack && mack < 0) mack = cyc;
      if (c0_rd_ack) begin
        ack_cnt++;
        if (ack_cyc < 0) begin
          ack_cyc = cyc;
          n_chk++;
          if (c0_rd_data[7:0] !== 8'h80) begin n_fail++; $display("FAIL slow_data: got %h want 80", c0_rd_data[7:0]); end
        end
        drop = 1'b1;
      end
      @(posedge clk); #1;
      if (drop) c0_rd_rq = 1'b0;
    end
    mem_lat = 1;
    n_chk++;
    if (rqc !== 5) begin n_fail++; $display("FAIL slow_rq_cycles: got %0d want 5", rqc); end
    n_chk++;
    if (mack !== 6 || ack_cyc !== 7) begin n_fail++; $display("FAIL slow_ack_timing: got mem=%0d req=%0d want 6 7", mack, ack_cyc); end
    n_chk++;
    if (ack_cnt !== 1) begin n_fail++; $display("FAIL slow_ack_width: got %0d want 1", ack_cnt); end
    n_chk++;
    if (busy_bad !== 0) begin n_fail++; $display("FAIL slow_busy: got %0d low cycles want 0", busy_bad); end
  endtask

  // Reset while in ISSUE, then a stale memory ack: nothing is acked.
  task automatic test_reset_in_issue;
    mem_lat = 5;
    c0_rd_addr = 16'h0300; c0_rd_rq = 1'b1;
    @(negedge clk); // cycle 0
    @(negedge clk); // cycle 1
    n_chk++;
    if ({arb_busy, mem_rd_rq} !== 2'b11) begin n_fail++; $display("FAIL rii_issue: got busy,rq=%b want 11", {arb_busy, mem_rd_rq}); end
    @(posedge clk); #1 rst = 1'b1; c0_rd_rq = 1'b0;
    @(posedge clk); #1 rst = 1'b0; inj_rd_ack = 1'b1;
    @(negedge clk); // first cycle after reset, stale ack present
    n_chk++;
    if ({c0_rd_ack, c1_rd_ack, arb_busy, mem_rd_rq} !== 4'b0000) begin
      n_fail++; $display("FAIL rii_stale: got %b want 0000", {c0_rd_ack, c1_rd_ack, arb_busy, mem_rd_rq});
    end
    @(posedge clk); #1 inj_rd_ack = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({c0_rd_ack, c1_rd_ack, c1_wr_ack, arb_busy} !== 4'b0000 || c0_rd_data !== '0) begin
      n_fail++; $display("FAIL rii_after: got %b data0=%h want 0000 00", {c0_rd_ack, c1_rd_ack, c1_wr_ack, arb_busy}, c0_rd_data[7:0]);
    end
    @(posedge clk); #1;
    mem_lat = 1;
  endtask

  // Both readers held: grant order depends on the arbitration build option.
  task automatic test_back_to_back;
    int who [4];
    int when [4];
    int ng;
    int exp_who [4];
`ifdef MEM_ARB_RR_EN
    exp_who = '{0, 1, 0, 1};
`else
    exp_who = '{1, 1, 1, 1};
`endif
    ng = 0;
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    c0_rd_addr = 16'h0150; c1_rd_addr = 16'h0265;
    c0_rd_rq = 1'b1; c1_rd_rq = 1'b1;
    for (int cyc = 0; cyc < 40 && ng < 4; cyc++) begin
      @(negedge clk);
      if (c0_rd_ack && c1_rd_ack) begin
        n_chk++; n_fail++; $display("FAIL b2b_both_ack: cyc %0d", cyc);
      end else if (c0_rd_ack) begin
        who[ng] = 0; when[ng] = cyc; ng++;
        n_chk++;
        if (c0_rd_data[7:0] !== 8'h40) begin n_fail++; $display("FAIL b2b_c0_data: got %h want 40", c0_rd_data[7:0]); end
      end else if (c1_rd_ack) begin
        who[ng] = 1; when[ng] = cyc; ng++;
        n_chk++;
        if (c1_rd_data[7:0] !== 8'h60) begin n_fail++; $display("FAIL b2b_c1_data: got %h want 60", c1_rd_data[7:0]); end
      end
      @(posedge clk); #1;
    end
    c0_rd_rq = 1'b0; c1_rd_rq = 1'b0;
    n_chk++;
    if (ng !== 4) begin
      n_fail++; $display("FAIL b2b_timeout: got %0d grants want 4", ng);
    end else begin
      for (int g = 0; g < 4; g++) begin
        n_chk++;
        if (who[g] !== exp_who[g]) begin n_fail++; $display("FAIL b2b_order g%0d: got c%0d want c%0d", g, who[g], exp_who[g]); end
      end
      n_chk++;
      if (when[0] !== 3 || when[1] !== 7 || when[2] !== 11 || when[3] !== 15) begin
        n_fail++; $display("FAIL b2b_spacing: got %0d %0d %0d %0d want 3 7 11 15", when[0], when[1], when[2], when[3]);
      end
    end
    @(negedge clk);
    n_chk++;
    if (arb_busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got %b want 0", arb_busy); end
    @(posedge clk); #1;
  endtask

  initial begin
    mem_lat = 1;
    inj_rd_ack = 1'b0;
    test_reset;
    test_c0_read;
    test_wr_then_rd;
    test_slow_mem;
    test_reset_in_issue;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
